// File: rtl/booth_multiplier_seq_if.sv
// ---------------------------------------------------------------------------
// booth_multiplier_seq_if
// Purpose : bundles the operand handshake and result signals of the
//           sequential Booth multiplier so that the source and the
//           multiplier can be connected through one port.
// Signals : start        - request from the operand source
//           multiplier   - signed operand Q
//           multiplicand - signed operand M
//           busy         - multiplier is computing or transmitting
//           done         - one-cycle pulse, product valid
//           product      - registered 2*WIDTH-bit signed result
//           tx           - framed serial copy of the product, idles high
// Modports: master drives the operands, slave is the multiplier itself.
// ---------------------------------------------------------------------------
interface booth_multiplier_seq_if #(
    parameter int WIDTH = 4
) ();
    logic                   start;
    logic [WIDTH-1:0]       multiplier;
    logic [WIDTH-1:0]       multiplicand;
    logic                   busy;
    logic                   done;
    logic [2*WIDTH-1:0]     product;
    logic                   tx;

    modport master (
        output start, multiplier, multiplicand,
        input  busy, done, product, tx
    );

    modport slave (
        input  start, multiplier, multiplicand,
        output busy, done, product, tx
    );
endinterface

// File: rtl/booth_multiplier_seq.sv
// ---------------------------------------------------------------------------
// booth_multiplier_seq
// Purpose : iterative radix-2 Booth signed multiplier. One Booth step per
//           clock; on completion the exact product is held on a parallel
//           port and also shifted out on a framed serial line
//           (start bit 0, product LSB first, stop bit 1).
// Ports   : CLK - clock, all state changes on the rising edge
//           rst - synchronous active-high reset
//           bus - booth_multiplier_seq_if.slave (start, multiplier,
//                 multiplicand in; busy, done, product, tx out)
// ---------------------------------------------------------------------------
module booth_multiplier_seq #(
    parameter int WIDTH = 4
) (
    input  logic                  CLK,
    input  logic                  rst,
    booth_multiplier_seq_if.slave bus
);
    // Step counter holds WIDTH..1, bit counter walks 0..2*WIDTH+1 over a frame.
    localparam int SCW = $clog2(WIDTH + 1);
    localparam int BCW = $clog2(2 * WIDTH + 2);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        SEND
    } state_t;

    state_t               r_state,    w_stateNext;
    logic [WIDTH:0]       r_acc,      w_accNext;
    logic [WIDTH:0]       r_m,        w_mNext;
    logic [WIDTH-1:0]     r_q,        w_qNext;
    logic                 r_qMinus,   w_qMinusNext;
    logic [SCW-1:0]       r_stepCnt,  w_stepCntNext;
    logic [BCW-1:0]       r_bitCnt,   w_bitCntNext;
    logic [2*WIDTH-1:0]   r_product,  w_productNext;
    logic [2*WIDTH-1:0]   r_txShift,  w_txShiftNext;
    logic                 r_busy,     w_busyNext;
    logic                 r_done,     w_doneNext;
    logic                 r_tx,       w_txNext;

    logic [WIDTH:0]       w_sum;
    logic [WIDTH:0]       w_shAcc;
    logic [WIDTH-1:0]     w_shQ;

    // One Booth step: add or subtract M according to the pair {Q[0],q_minus},
    // then arithmetic-shift {acc,Q,q_minus} right by one. acc carries one
    // extra bit so that subtracting the most negative M cannot overflow.
    always_comb begin
        w_sum = r_acc;
        case ({r_q[0], r_qMinus})
            2'b10:   w_sum = r_acc - r_m;
            2'b01:   w_sum = r_acc + r_m;
            default: w_sum = r_acc;
        endcase
        w_shAcc = {w_sum[WIDTH], w_sum[WIDTH:1]};
        w_shQ   = {w_sum[0], r_q[WIDTH-1:1]};
    end

    // Next-state and next-output logic. Everything holds by default; only
    // the branch of the current state changes what it owns. done is the only
    // pulse and therefore defaults to 0 instead of holding.
    always_comb begin
        w_stateNext   = r_state;
        w_accNext     = r_acc;
        w_mNext       = r_m;
        w_qNext       = r_q;
        w_qMinusNext  = r_qMinus;
        w_stepCntNext = r_stepCnt;
        w_bitCntNext  = r_bitCnt;
        w_productNext = r_product;
        w_txShiftNext = r_txShift;
        w_busyNext    = r_busy;
        w_doneNext    = 1'b0;
        w_txNext      = r_tx;

        case (r_state)
            IDLE: begin
                w_txNext = 1'b1;
                if (bus.start) begin
                    w_mNext       = {bus.multiplicand[WIDTH-1], bus.multiplicand};
                    w_qNext       = bus.multiplier;
                    w_accNext     = '0;
                    w_qMinusNext  = 1'b0;
                    w_stepCntNext = SCW'(WIDTH);
                    w_busyNext    = 1'b1;
                    w_stateNext   = CALC;
                end
            end

            CALC: begin
                w_accNext     = w_shAcc;
                w_qNext       = w_shQ;
                w_qMinusNext  = r_q[0];
                w_stepCntNext = r_stepCnt - SCW'(1);
                // Last step: the shifted result is already the final product,
                // so publish it and emit the start bit on the same edge.
                if (r_stepCnt == SCW'(1)) begin
                    w_productNext = {w_shAcc[WIDTH-1:0], w_shQ};
                    w_txShiftNext = {w_shAcc[WIDTH-1:0], w_shQ};
                    w_doneNext    = 1'b1;
                    w_txNext      = 1'b0;
                    w_bitCntNext  = '0;
                    w_stateNext   = SEND;
                end
            end

            SEND: begin
                // Data bits come from a private copy of the product so that
                // the parallel port stays untouched while shifting.
                if (r_bitCnt < BCW'(2 * WIDTH)) begin
                    w_txNext      = r_txShift[0];
                    w_txShiftNext = r_txShift >> 1;
                    w_bitCntNext  = r_bitCnt + BCW'(1);
                end else if (r_bitCnt == BCW'(2 * WIDTH)) begin
                    w_txNext     = 1'b1;
                    w_bitCntNext = r_bitCnt + BCW'(1);
                end else begin
                    w_txNext    = 1'b1;
                    w_busyNext  = 1'b0;
                    w_stateNext = IDLE;
                end
            end

            default: begin
                w_txNext    = 1'b1;
                w_busyNext  = 1'b0;
                w_stateNext = IDLE;
            end
        endcase
    end

    // State register. Reset wins over everything, so a frame in flight is
    // cut off immediately with the line returned to idle-high.
    always_ff @(posedge CLK) begin
        if (rst) begin
            r_state   <= IDLE;
            r_acc     <= '0;
            r_m       <= '0;
            r_q       <= '0;
            r_qMinus  <= 1'b0;
            r_stepCnt <= '0;
            r_bitCnt  <= '0;
            r_product <= '0;
            r_txShift <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_tx      <= 1'b1;
        end else begin
            r_state   <= w_stateNext;
            r_acc     <= w_accNext;
            r_m       <= w_mNext;
            r_q       <= w_qNext;
            r_qMinus  <= w_qMinusNext;
            r_stepCnt <= w_stepCntNext;
            r_bitCnt  <= w_bitCntNext;
            r_product <= w_productNext;
            r_txShift <= w_txShiftNext;
            r_busy    <= w_busyNext;
            r_done    <= w_doneNext;
            r_tx      <= w_txNext;
        end
    end

    assign bus.busy    = r_busy;
    assign bus.done    = r_done;
    assign bus.product = r_product;
    assign bus.tx      = r_tx;
endmodule

// File: tb/tb_booth_multiplier_seq.sv
// ---------------------------------------------------------------------------
// tb_booth_multiplier_seq
// Purpose : self-checking bench for booth_multiplier_seq. A WIDTH=4 and a
//           WIDTH=8 instance share clock and reset; expected products and
//           serial frames come from plain signed multiplication.
// ---------------------------------------------------------------------------
module tb_booth_multiplier_seq;
    logic CLK;
    logic rst;
    int   nCompared;
    int   nMismatched;

    booth_multiplier_seq_if #(.WIDTH(4)) bus4 ();
    booth_multiplier_seq_if #(.WIDTH(8)) bus8 ();

    booth_multiplier_seq #(.WIDTH(4)) dut4 (
        .CLK (CLK),
        .rst (rst),
        .bus (bus4)
    );

    booth_multiplier_seq #(.WIDTH(8)) dut8 (
        .CLK (CLK),
        .rst (rst),
        .bus (bus8)
    );

    // Free-running 10 ns clock.
    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // Hard time limit so a stuck design can never hang the run.
    initial begin
        #3_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    // Reference products: exact signed multiply, truncated to 2*WIDTH bits.
    function automatic logic [7:0] model4(input logic [3:0] q, input logic [3:0] m);
        int p;
        p = int'($signed(q)) * int'($signed(m));
        return p[7:0];
    endfunction

    function automatic logic [15:0] model8(input logic [7:0] q, input logic [7:0] m);
        int p;
        p = int'($signed(q)) * int'($signed(m));
        return p[15:0];
    endfunction

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        nCompared++;
        assert (observed === expected)
        else begin
            nMismatched++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Run one WIDTH=4 operation and follow it through the whole frame.
    // With interfere set, extra start requests are raised during CALC and
    // during SEND; they must leave the result and frame untouched.
    task automatic applyStimulus(input logic [3:0] q, input logic [3:0] m,
                                 input bit interfere);
        logic [7:0] exp;
        int         lat;
        bit         gotDone;
        exp = model4(q, m);
        bus4.start        = 1'b1;
        bus4.multiplier   = q;
        bus4.multiplicand = m;
        tick();
        bus4.start        = 1'b0;
        bus4.multiplier   = 4'($urandom);
        bus4.multiplicand = 4'($urandom);
        checkOutput("busyAfterStart", 64'(bus4.busy), 64'(1));
        lat     = 0;
        gotDone = 1'b0;
        while (!gotDone && lat < 12) begin
            if (interfere && lat == 1) begin
                bus4.start        = 1'b1;
                bus4.multiplier   = ~q;
                bus4.multiplicand = q ^ 4'h5;
            end else begin
                bus4.start = 1'b0;
            end
            tick();
            lat++;
            gotDone = bus4.done;
        end
        bus4.start = 1'b0;
        checkOutput("doneLatency", 64'(lat), 64'(4));
        checkOutput($sformatf("product %0d*%0d", $signed(q), $signed(m)),
                    64'(bus4.product), 64'(exp));
        checkOutput("startBit", 64'(bus4.tx), 64'(0));
        for (int i = 0; i < 8; i++) begin
            if (interfere && i == 3) begin
                bus4.start        = 1'b1;
                bus4.multiplier   = 4'($urandom);
                bus4.multiplicand = 4'($urandom);
            end else begin
                bus4.start = 1'b0;
            end
            tick();
            checkOutput($sformatf("dataBit%0d", i), 64'(bus4.tx), 64'(exp[i]));
            checkOutput("busyInFrame", 64'(bus4.busy), 64'(1));
            checkOutput("doneLow", 64'(bus4.done), 64'(0));
        end
        bus4.start = 1'b0;
        tick();
        checkOutput("stopBit", 64'(bus4.tx), 64'(1));
        checkOutput("busyInStop", 64'(bus4.busy), 64'(1));
        tick();
        checkOutput("busyFall", 64'(bus4.busy), 64'(0));
        checkOutput("txIdle", 64'(bus4.tx), 64'(1));
        checkOutput("productHeld", 64'(bus4.product), 64'(exp));
    endtask

    // Same flow for the WIDTH=8 instance: 8-cycle latency, 18-cycle frame.
    task automatic applyStimulus8(input logic [7:0] q, input logic [7:0] m);
        logic [15:0] exp;
        int          lat;
        bit          gotDone;
        exp = model8(q, m);
        bus8.start        = 1'b1;
        bus8.multiplier   = q;
        bus8.multiplicand = m;
        tick();
        bus8.start = 1'b0;
        lat        = 0;
        gotDone    = 1'b0;
        while (!gotDone && lat < 24) begin
            tick();
            lat++;
            gotDone = bus8.done;
        end
        checkOutput("w8 doneLatency", 64'(lat), 64'(8));
        checkOutput($sformatf("w8 product %0d*%0d", $signed(q), $signed(m)),
                    64'(bus8.product), 64'(exp));
        checkOutput("w8 startBit", 64'(bus8.tx), 64'(0));
        for (int i = 0; i < 16; i++) begin
            tick();
            checkOutput($sformatf("w8 dataBit%0d", i), 64'(bus8.tx), 64'(exp[i]));
        end
        tick();
        checkOutput("w8 stopBit", 64'(bus8.tx), 64'(1));
        checkOutput("w8 busyInStop", 64'(bus8.busy), 64'(1));
        tick();
        checkOutput("w8 busyFall", 64'(bus8.busy), 64'(0));
    endtask

    task automatic checkResetState(input string tag);
        checkOutput({tag, " busy"}, 64'(bus4.busy), 64'(0));
        checkOutput({tag, " done"}, 64'(bus4.done), 64'(0));
        checkOutput({tag, " tx"}, 64'(bus4.tx), 64'(1));
        checkOutput({tag, " product"}, 64'(bus4.product), 64'(0));
    endtask

    // Directed sequence: reset, test-plan operands, exhaustive sweep,
    // interference, resets in flight, then the WIDTH=8 corners and randoms.
    initial begin
        nCompared         = 0;
        nMismatched       = 0;
        rst               = 1'b1;
        bus4.start        = 1'b0;
        bus4.multiplier   = '0;
        bus4.multiplicand = '0;
        bus8.start        = 1'b0;
        bus8.multiplier   = '0;
        bus8.multiplicand = '0;
        tick();
        tick();
        checkResetState("reset");
        checkOutput("w8 reset tx", 64'(bus8.tx), 64'(1));
        checkOutput("w8 reset busy", 64'(bus8.busy), 64'(0));
        rst = 1'b0;
        tick();

        $display("[TB] directed operands");
        applyStimulus(4'd3, 4'hE, 1'b0);
        applyStimulus(4'h8, 4'h8, 1'b0);
        applyStimulus(4'h8, 4'h7, 1'b0);
        applyStimulus(4'h7, 4'h7, 1'b0);
        applyStimulus(4'h0, 4'hB, 1'b0);

        $display("[TB] exhaustive sweep");
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                applyStimulus(4'(a), 4'(b), 1'b0);
            end
        end

        $display("[TB] start requests while busy");
        applyStimulus(4'd3, 4'hE, 1'b1);
        for (int k = 0; k < 6; k++) begin
            applyStimulus(4'($urandom), 4'($urandom), 1'b1);
        end

        $display("[TB] reset during CALC");
        bus4.start        = 1'b1;
        bus4.multiplier   = 4'd3;
        bus4.multiplicand = 4'hE;
        tick();
        bus4.start = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        checkResetState("rstCalc");
        rst = 1'b0;
        tick();
        checkResetState("rstCalcIdle");
        applyStimulus(4'd5, 4'd5, 1'b0);

        $display("[TB] reset mid-frame");
        bus4.start        = 1'b1;
        bus4.multiplier   = 4'd7;
        bus4.multiplicand = 4'd7;
        tick();
        bus4.start = 1'b0;
        for (int k = 0; k < 7; k++) begin
            tick();
        end
        rst = 1'b1;
        tick();
        checkResetState("rstFrame");
        rst = 1'b0;
        applyStimulus(4'd5, 4'd5, 1'b0);

        $display("[TB] WIDTH=8 operands");
        applyStimulus8(8'h80, 8'h80);
        applyStimulus8(8'h7F, 8'h80);
        for (int k = 0; k < 20; k++) begin
            applyStimulus8(8'($urandom), 8'($urandom));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end
endmodule
